load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BIG_ENDIAN, default 1: byte offset 0 maps to bits 31:24; 0 maps it to bits 7:0.
REQ-002 Parameter ADDR_W, default 32: width of ReqAddr and MemAddress.
REQ-003 Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 ReqValid  in  1  pipeline request present.
REQ-006 ReqReady  out  1  unit accepts a request this cycle.
REQ-007 ReqWrite  in  1  1 = store, 0 = load.
REQ-008 ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 ReqSigned  in  1  sign-extend sub-word loads.
REQ-010 ReqAddr  in  ADDR_W  byte address.
REQ-011 ReqWData  in  32  store data, right-justified.
REQ-012 RespValid  out  1  one-cycle completion pulse.
REQ-013 RespData  out  32  extended load result; 0 for stores.
REQ-014 MemAddress  out  ADDR_W  word-aligned address to DataMem (bits 1:0 = 00).
REQ-015 MemWriteData  out  32  full word to DataMem.
REQ-016 MemRead / MemWrite  out  1 each  DataMem enables, never both high.
REQ-017 MemReadData  in  32  DataMem output, valid the cycle after MemRead is high.

Function
REQ-018 FSM states IDLE, RD, RWAIT, WR, RESP; ReqReady = 1 only in IDLE.
REQ-019 Accept on ReqValid & ReqReady; latch ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData.
REQ-020 Load: IDLE->RD (MemRead=1)->RWAIT (capture MemReadData)->RESP->IDLE; RespValid 3 cycles after accept.
REQ-021 Word store: IDLE->WR (MemWrite=1, MemWriteData=latched data)->RESP; RespValid 2 cycles after accept.
REQ-022 Byte/halfword store: read-modify-write IDLE->RD->RWAIT->WR->RESP; only the addressed lane(s) replaced; RespValid 4 cycles after accept.
REQ-023 Lane select from ReqAddr[1:0] per BIG_ENDIAN; halfword uses ReqAddr[1] only.
REQ-024 Loads: byte/halfword zero-extended, or sign-extended when ReqSigned = 1; word unchanged.
REQ-025 ReqValid while not in IDLE is ignored and not queued.
REQ-026 Outside RD/WR: MemRead = 0, MemWrite = 0, MemAddress and MemWriteData hold last value.
REQ-027 RespData held until next RESP; RespValid high exactly one cycle per accepted request.

Reset
REQ-028 Reset asynchronously forces IDLE, ReqReady=1 after release, RespValid=0, RespData=0, MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
REQ-029 Reset mid-operation aborts the request without a response; a partially started RMW issues no write.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: adds output MisalignErr (1 bit, reset 0); halfword with ReqAddr[0]=1 or word with ReqAddr[1:0]!=0 goes IDLE->RESP, no memory access, RespValid and MisalignErr high together, RespData=0.
REQ-031 Macro undefined: no MisalignErr port; misaligned low address bits ignored and access proceeds aligned.

Structure
REQ-032 Package lsu_pkg holds ReqSize encodings, FSM state enum and lane-select helper constants.
REQ-033 Sub-module byte_lane_merge (combinational): lane insertion for stores and lane extraction/extension for loads.

Verification
REQ-034 Reset, then SW addr 8 data 0xDEADBEEF -> MemWrite pulse 1 cycle, MemAddress 8, RespValid 2 cycles after accept.
REQ-035 LW addr 8 after REQ-034 -> MemRead 1 cycle, RespData 0xDEADBEEF 3 cycles after accept.
REQ-036 SB addr 9 data 0x55, BIG_ENDIAN=1 -> memory word 8 becomes 0xDE55BEEF; LB signed addr 9 -> 0x00000055; LB signed addr 8 -> 0xFFFFFFDE.
REQ-037 LH unsigned addr 10 on word 0xDE55BEEF -> 0x0000BEEF; ReqValid held high during busy -> exactly one response per accept.
REQ-038 Reset asserted in RWAIT of SB -> no MemWrite, no RespValid, ReqReady=1 the cycle after release.
REQ-039 With LSU_MISALIGN_TRAP_EN, LW addr 6 -> no MemRead/MemWrite, RespValid and MisalignErr 1 cycle after accept, RespData 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and lane helpers.
// Optional misaligned-access trapping is selected in the top level by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
    localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // Bit position of the addressed lane inside the 32-bit word; 3 - offset == ~offset for 2 bits.
    function automatic logic [4:0] lane_shift(input logic big_endian,
                                              input logic [1:0] size,
                                              input logic [1:0] offset);
        logic [4:0] shift;
        case (size)
            SIZE_BYTE: shift = big_endian ? {~offset, 3'b000} : {offset, 3'b000};
            SIZE_HALF: shift = big_endian ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
            default:   shift = 5'd0;
        endcase
        return shift;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane logic: inserts store data into a read word and extracts/extends load data.
module byte_lane_merge
    import lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
)(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
        shift = lane_shift(BIG_ENDIAN != 0, size, offset);
        case (size)
            SIZE_BYTE: mask = BYTE_MASK;
            SIZE_HALF: mask = HALF_MASK;
            default:   mask = WORD_MASK;
        endcase

        merged = (mem_word & ~(mask << shift)) | ((store_data & mask) << shift);
        lane   = (mem_word >> shift) & mask;

        case (size)
            SIZE_BYTE: load_data = is_signed ? {{24{lane[7]}}, lane[7:0]} : lane;
            SIZE_HALF: load_data = is_signed ? {{16{lane[15]}}, lane[15:0]} : lane;
            default:   load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit with read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to add the MisalignErr output and trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 1,
    parameter int ADDR_W     = 32
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              RespValid,
    output logic [31:0]       RespData,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       MemReadData
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              MisalignErr
`endif
);

    lsu_state_e  state, state_next;
    logic        accept;
    logic        trap_req;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;
    logic [31:0] load_data;

    assign accept    = ReqValid && ReqReady;
    assign ReqReady  = (state == ST_IDLE);
    assign MemRead   = (state == ST_RD);
    assign MemWrite  = (state == ST_WR);
    assign RespValid = (state == ST_RESP);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap_req    = is_misaligned(ReqSize, ReqAddr[1:0]);
    assign MisalignErr = (state == ST_RESP) && mis_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            mis_q <= 1'b0;
        else if (accept)
            mis_q <= trap_req;
    end
`else
    assign trap_req = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Word stores skip the read; sub-word stores read, merge, then write.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (trap_req)
                        state_next = ST_RESP;
                    else if (ReqWrite && ReqSize[1])
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD:    state_next = ST_RWAIT;
            ST_RWAIT: state_next = write_q ? ST_WR : ST_RESP;
            ST_WR:    state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    byte_lane_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .size       (size_q),
        .is_signed  (signed_q),
        .offset     (offset_q),
        .store_data (wdata_q),
        .mem_word   (MemReadData),
        .merged     (merged),
        .load_data  (load_data)
    );

    // Memory-side registers only change on entry to an access, so they hold between accesses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= SIZE_BYTE;
            offset_q     <= 2'b00;
            wdata_q      <= 32'h0;
            MemAddress   <= '0;
            MemWriteData <= 32'h0;
            RespData     <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= ReqWrite;
                signed_q <= ReqSigned;
                size_q   <= ReqSize;
                offset_q <= ReqAddr[1:0];
                wdata_q  <= ReqWData;
                if (!trap_req)
                    MemAddress <= {ReqAddr[ADDR_W-1:2], 2'b00};
            end
            if (state_next == ST_WR && state != ST_WR)
                MemWriteData <= (state == ST_IDLE) ? ReqWData : merged;
            if (state_next == ST_RESP && state != ST_RESP)
                RespData <= (state == ST_RWAIT && !write_q) ? load_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus reset, busy-hold and misalign sequences.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        MisalignErr;
`endif

    always #5 Clk = ~Clk;

    load_store_unit #(.BIG_ENDIAN(1), .ADDR_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqSigned    (ReqSigned),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .RespValid    (RespValid),
        .RespData     (RespData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemReadData  (MemReadData)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .MisalignErr  (MisalignErr)
`endif
    );

    // Data memory model: synchronous write, registered read data one cycle after MemRead.
    logic [31:0] mem [0:15];
    logic        mem_clear;

    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            MemReadData <= 32'h0;
        end else begin
            if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
            if (MemRead)  MemReadData <= mem[MemAddress[5:2]];
        end
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_addr = 32'h0;

    always @(negedge Clk) begin
        if (MemRead)  rd_cnt <= rd_cnt + 1;
        if (MemWrite) wr_cnt <= wr_cnt + 1;
        if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
        if (MemRead || MemWrite) last_addr <= MemAddress;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqSize   = size;
        ReqSigned = sgn;
        ReqAddr   = addr;
        ReqWData  = wdata;
    endtask

    // Issue one request at a negedge and measure the cycles until RespValid.
    task automatic run_req(input string name, input vec_t v);
        int rd0;
        int wr0;
        int cyc;
        @(negedge Clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        check({name, " ready"}, 32'(ReqReady), 32'd1);
        drive(v.wr, v.size, v.sgn, v.addr, v.wdata);
        @(negedge Clk);
        ReqValid = 1'b0;
        cyc = 1;
        while (!RespValid && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        check({name, " data"}, RespData, v.exp_data);
        check({name, " writes"}, 32'(wr_cnt - wr0), v.wr ? 32'd1 : 32'd0);
        check({name, " reads"}, 32'(rd_cnt - rd0), (v.wr && v.size[1]) ? 32'd0 : 32'd1);
        check({name, " addr"}, last_addr, {v.addr[31:2], 2'b00});
`ifdef LSU_MISALIGN_TRAP_EN
        check({name, " no misalign"}, 32'(MisalignErr), 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        int resp_seen;
        int wr0;
        int rd0;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'd8,  32'hDEADBEEF, 32'h00000000, 2};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'hDEADBEEF, 3};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'd9,  32'h00000055, 32'h00000000, 4};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'hDE55BEEF, 3};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'd9,  32'h0,        32'h00000055, 3};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'd8,  32'h0,        32'hFFFFFFDE, 3};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'd10, 32'h0,        32'h0000BEEF, 3};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'd10, 32'h0,        32'hFFFFBEEF, 3};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'd8,  32'h0,        32'h000000DE, 3};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'd8,  32'h12345678, 32'h00000000, 4};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'd8,  32'h0,        32'h5678BEEF, 3};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'd11, 32'h0,        32'hFFFFFFEF, 3};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 32'd4,  32'h000000AB, 32'h00000000, 4};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 32'd4,  32'h0,        32'hFFFFAB00, 3};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'd4,  32'h0,        32'hAB000000, 3};

        Reset     = 1'b1;
        mem_clear = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqSize   = 2'b00;
        ReqSigned = 1'b0;
        ReqAddr   = 32'h0;
        ReqWData  = 32'h0;
        repeat (3) @(negedge Clk);
        check("rst RespValid", 32'(RespValid), 32'd0);
        check("rst RespData", RespData, 32'h0);
        check("rst MemRead", 32'(MemRead), 32'd0);
        check("rst MemWrite", 32'(MemWrite), 32'd0);
        check("rst MemAddress", MemAddress, 32'h0);
        check("rst MemWriteData", MemWriteData, 32'h0);
        Reset     = 1'b0;
        mem_clear = 1'b0;
        @(negedge Clk);
        check("rst ReqReady", 32'(ReqReady), 32'd1);

        for (int i = 0; i < 15; i++)
            run_req($sformatf("vec%0d", i), vecs[i]);
        check("MemWriteData holds", MemWriteData, 32'hAB000000);

        // Reset during RWAIT of a byte store: no write, no response.
        @(negedge Clk);
        wr0 = wr_cnt;
        drive(1'b1, 2'b00, 1'b0, 32'd9, 32'h00000077);
        @(negedge Clk);
        ReqValid = 1'b0;
        @(negedge Clk);
        check("abort in RWAIT", 32'(MemRead || MemWrite || RespValid || ReqReady), 32'd0);
        Reset = 1'b1;
        resp_seen = 0;
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (k == 0) check("abort ReqReady", 32'(ReqReady), 32'd1);
            if (RespValid) resp_seen++;
        end
        check("abort no resp", 32'(resp_seen), 32'd0);
        check("abort no write", 32'(wr_cnt - wr0), 32'd0);
        run_req("after abort", '{1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h5678BEEF, 3});

        // ReqValid held through the busy period yields one response only.
        @(negedge Clk);
        rd0 = rd_cnt;
        drive(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        resp_seen = 0;
        cyc = 0;
        while (resp_seen == 0 && cyc < 10) begin
            @(negedge Clk);
            cyc++;
            if (RespValid) begin
                resp_seen++;
                check("busy data", RespData, 32'hAB000000);
                ReqValid = 1'b0;
            end
        end
        check("busy latency", 32'(cyc), 32'd3);
        repeat (5) begin
            @(negedge Clk);
            if (RespValid) resp_seen++;
        end
        check("busy one resp", 32'(resp_seen), 32'd1);
        check("busy one read", 32'(rd_cnt - rd0), 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word and halfword trap without touching memory.
        for (int m = 0; m < 2; m++) begin
            @(negedge Clk);
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            if (m == 0) drive(1'b0, 2'b10, 1'b0, 32'd6, 32'h0);
            else        drive(1'b1, 2'b01, 1'b0, 32'd9, 32'h1234);
            @(negedge Clk);
            ReqValid = 1'b0;
            check($sformatf("mis%0d RespValid", m), 32'(RespValid), 32'd1);
            check($sformatf("mis%0d MisalignErr", m), 32'(MisalignErr), 32'd1);
            check($sformatf("mis%0d RespData", m), RespData, 32'h0);
            check($sformatf("mis%0d no access", m), 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
            @(negedge Clk);
            check($sformatf("mis%0d err drops", m), 32'(MisalignErr), 32'd0);
        end
        run_req("after mis", '{1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h5678BEEF, 3});
`endif

        check("never read+write", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
